fetch_unit: RTL

Program-counter and fetch-control stage sitting directly upstream of the instruction ROM: it drives the 8-bit `InstrAddress` that the ROM decodes combinationally into the 9-bit instruction. It sequences execution through IDLE/RUN/HALTED, applies stalls, relative branches and LUT-based absolute branches, and reports completion to the top level and testbench.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Program-counter / fetch-control stage in front of the instruction ROM.
// Optional RUN-cycle counter is built only when FETCH_CYCLE_COUNT_EN is defined.
module fetch_unit #(
  parameter int              PC_W       = 8,
  parameter int              LUT_DEPTH  = 16,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            Stall,
  input  logic            BranchTaken,
  input  logic            BranchAbs,
  input  logic [4:0]      BranchOffset,
  input  logic            HaltReq,
  input  logic            LutWrEn,
  input  logic [3:0]      LutWrIdx,
  input  logic [PC_W-1:0] LutWrData,
  output logic [PC_W-1:0] InstrAddress,
  output logic            Running,
  output logic            Done,
  output logic            Wrapped,
  output logic [15:0]     CycleCount
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic            r_wrapped, w_wrapped_nxt;
  logic [PC_W-1:0] r_lut [LUT_DEPTH];
  logic [PC_W-1:0] w_rel_off;

  assign w_rel_off = {{(PC_W-5){BranchOffset[4]}}, BranchOffset};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_pc      <= START_ADDR;
      r_wrapped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_wrapped <= w_wrapped_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_wrapped_nxt = r_wrapped;
    case (r_state)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          w_state_nxt   = S_RUN;
          w_pc_nxt      = StartAddr;
          w_wrapped_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (HaltReq) begin
          w_state_nxt = S_HALTED;
        end else if (!Stall) begin
          // A stalled branch is simply dropped; decode re-asserts it next cycle.
          if (BranchTaken && !BranchAbs) begin
            w_pc_nxt = r_pc + w_rel_off;
          end else if (BranchTaken) begin
            w_pc_nxt = r_lut[BranchOffset[3:0]];
          end else begin
            w_pc_nxt = r_pc + PC_W'(1);
            if (r_pc == '1) w_wrapped_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the LUT is small and architecturally defined as zero after reset, so it is reset like any flop.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) r_lut[i] <= '0;
    end else if (LutWrEn) begin
      r_lut[LutWrIdx] <= LutWrData;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] r_cycle;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_cycle <= '0;
    end else if (r_state != S_RUN && Start) begin
      r_cycle <= '0;
    end else if (r_state == S_RUN && r_cycle != 16'hFFFF) begin
      r_cycle <= r_cycle + 16'd1;
    end
  end

  assign CycleCount = r_cycle;
`else
  assign CycleCount = 16'h0000;
`endif

  assign InstrAddress = r_pc;
  assign Running      = (r_state == S_RUN);
  assign Done         = (r_state == S_HALTED);
  assign Wrapped      = r_wrapped;

endmodule
